// File: rtl/pwl_biquad_bank_if.sv
// Config handshake for pwl_biquad_bank: mode plus PWL q/w0 (a, b, t0),
// valid/ready request and one-cycle reject pulse.
`timescale 1ns/1ps
interface pwl_biquad_bank_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_err;
  logic [1:0] mode;
  real        q_a;
  real        q_b;
  real        q_t0;
  real        w0_a;
  real        w0_b;
  real        w0_t0;

  modport master (
    output cfg_valid, mode,
    output q_a, q_b, q_t0,
    output w0_a, w0_b, w0_t0,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, mode,
    input  q_a, q_b, q_t0,
    input  w0_a, w0_b, w0_t0,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pwl_biquad_bank.sv
// Clocked NCH-channel PWL biquad (notch/LP/HP/BP), PWL times in seconds.
// Optional macro PWL_BIQUAD_PREWARP_EN: tan() prewarp plus near-Nyquist reject.
`timescale 1ns/1ps
module pwl_biquad_bank #(
  parameter int  NCH  = 4,
  parameter real TS   = 1e-9,
  parameter real QMIN = 0.05
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  pwl_biquad_bank_if.slave cfg,
  input  real  si_a  [NCH],
  input  real  si_b  [NCH],
  input  real  si_t0 [NCH],
  output real  so_a  [NCH],
  output real  so_b  [NCH],
  output real  so_t0 [NCH]
);

  typedef enum logic {RUN, COEF} st_t;

  st_t        st;
  st_t        st_n;
  logic       ok;
  logic       acc;
  real        qv;
  real        wv;
  real        q_s;
  real        w0_s;
  logic [1:0] m_s;
  real        b0, b1, b2, a1, a2;
  real        kk, kq, n;
  real        nb0, nb1, nb2, na1, na2;
  real        s1 [NCH];
  real        s2 [NCH];
  real        yp [NCH];

  function automatic real now();
    return $realtime * 1e-9;
  endfunction

  function automatic real ev(real a, real b, real t0);
    return a + b * (now() - t0);
  endfunction

  // NaN and +/-Inf both fail v - v == 0
  function automatic logic fin(real v);
    return (v - v) == 0.0;
  endfunction

  function automatic real xv(int c);
    return ev(si_a[c], si_b[c], si_t0[c]);
  endfunction

  function automatic real yv(int c);
    return b0 * xv(c) + s1[c];
  endfunction

  always_comb begin
    qv = ev(cfg.q_a, cfg.q_b, cfg.q_t0);
    wv = ev(cfg.w0_a, cfg.w0_b, cfg.w0_t0);
    ok = fin(qv) && fin(wv) && qv >= QMIN && wv > 0.0;
`ifdef PWL_BIQUAD_PREWARP_EN
    ok = ok && (wv * TS / 2.0 < 1.5);
`endif
    st_n          = st;
    acc           = 1'b0;
    cfg.cfg_ready = 1'b0;
    unique case (st)
      RUN: begin
        cfg.cfg_ready = !rst;
        acc           = cfg.cfg_valid && ok;
        if (acc) st_n = COEF;
      end
      COEF: st_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= RUN;
    else     st <= st_n;
  end

  always_comb begin
`ifdef PWL_BIQUAD_PREWARP_EN
    kk = $tan(w0_s * TS / 2.0);
`else
    kk = w0_s * TS / 2.0;
`endif
    kq  = kk / q_s;
    n   = 1.0 / (1.0 + kq + kk * kk);
    na1 = 2.0 * (kk * kk - 1.0) * n;
    na2 = (1.0 - kq + kk * kk) * n;
    nb0 = (1.0 + kk * kk) * n;
    nb1 = na1;
    nb2 = nb0;
    unique case (m_s)
      2'd1: begin
        nb0 = kk * kk * n;
        nb1 = 2.0 * nb0;
        nb2 = nb0;
      end
      2'd2: begin
        nb0 = n;
        nb1 = -2.0 * n;
        nb2 = n;
      end
      2'd3: begin
        nb0 = kq * n;
        nb1 = 0.0;
        nb2 = -nb0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.cfg_err <= 1'b0;
      q_s         <= 1.0;
      w0_s        <= 0.0;
      m_s         <= 2'd0;
      b0          <= 1.0;
      b1          <= 0.0;
      b2          <= 0.0;
      a1          <= 0.0;
      a2          <= 0.0;
      for (int c = 0; c < NCH; c++) begin
        s1[c]    <= 0.0;
        s2[c]    <= 0.0;
        yp[c]    <= 0.0;
        so_a[c]  <= 0.0;
        so_b[c]  <= 0.0;
        so_t0[c] <= now();
      end
    end else begin
      cfg.cfg_err <= (st == RUN) && cfg.cfg_valid && !ok;
      if (acc) begin
        q_s  <= qv;
        w0_s <= wv;
        m_s  <= cfg.mode;
      end
      if (st == COEF) begin
        b0 <= nb0;
        b1 <= nb1;
        b2 <= nb2;
        a1 <= na1;
        a2 <= na2;
      end
      for (int c = 0; c < NCH; c++) begin
        // frozen channels park the output flat at its present value
        if (st == COEF || !en) begin
          so_a[c]  <= so_a[c] + so_b[c] * (now() - so_t0[c]);
          so_b[c]  <= 0.0;
          so_t0[c] <= now();
        end else if (!fin(yv(c))) begin
          s1[c]    <= 0.0;
          s2[c]    <= 0.0;
          yp[c]    <= 0.0;
          so_a[c]  <= 0.0;
          so_b[c]  <= 0.0;
          so_t0[c] <= now();
        end else begin
          s1[c]    <= b1 * xv(c) - a1 * yv(c) + s2[c];
          s2[c]    <= b2 * xv(c) - a2 * yv(c);
          so_a[c]  <= yp[c];
          so_b[c]  <= (yv(c) - yp[c]) / TS;
          so_t0[c] <= now();
          yp[c]    <= yv(c);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwl_biquad_bank.sv
// Bench for pwl_biquad_bank: random PWL samples against a per-channel
// difference-equation model, plus directed config/enable/reset scenarios.
`timescale 1ns/1ps
module tb_pwl_biquad_bank;
  localparam int  NCH = 4;
  localparam real TS  = 1e-9;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  real  si_a  [NCH];
  real  si_b  [NCH];
  real  si_t0 [NCH];
  real  so_a  [NCH];
  real  so_b  [NCH];
  real  so_t0 [NCH];

  pwl_biquad_bank_if ifc ();

  pwl_biquad_bank #(.NCH(NCH), .TS(TS), .QMIN(0.05)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .cfg   (ifc),
    .si_a  (si_a),
    .si_b  (si_b),
    .si_t0 (si_t0),
    .so_a  (so_a),
    .so_b  (so_b),
    .so_t0 (so_t0)
  );

  always #0.5 clk = ~clk;

  int  npass = 0;
  int  nchk  = 0;
  real mb0, mb1, mb2, ma1, ma2;
  real s1 [NCH];
  real s2 [NCH];
  real yp [NCH];
  real ea [NCH];
  real ee [NCH];

  function automatic bit close(real a, real b);
    real d;
    real m;
    d = (a > b) ? a - b : b - a;
    m = (b < 0.0) ? -b : b;
    return d <= 1e-9 + 1e-9 * m;
  endfunction

  function automatic real absr(real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real rnd();
    return (real'($urandom_range(2000)) - 1000.0) / 1000.0;
  endfunction

  function automatic void mreset();
    mb0 = 1.0; mb1 = 0.0; mb2 = 0.0; ma1 = 0.0; ma2 = 0.0;
    for (int c = 0; c < NCH; c++) begin
      s1[c] = 0.0; s2[c] = 0.0; yp[c] = 0.0;
      ea[c] = 0.0; ee[c] = 0.0;
    end
  endfunction

  function automatic void mcoef(int m, real qq, real ww);
    real k, k2, d;
`ifdef PWL_BIQUAD_PREWARP_EN
    k = $tan(ww * TS / 2.0);
`else
    k = ww * TS / 2.0;
`endif
    k2  = k * k;
    d   = 1.0 + k / qq + k2;
    ma1 = 2.0 * (k2 - 1.0) / d;
    ma2 = (1.0 - k / qq + k2) / d;
    case (m)
      0: begin mb0 = (1.0 + k2) / d; mb1 = ma1; mb2 = mb0; end
      1: begin mb0 = k2 / d; mb1 = 2.0 * k2 / d; mb2 = mb0; end
      2: begin mb0 = 1.0 / d; mb1 = -2.0 / d; mb2 = mb0; end
      default: begin mb0 = (k / qq) / d; mb1 = 0.0; mb2 = -mb0; end
    endcase
  endfunction

  // one filter sample per channel: expected ramp is prev -> new output
  function automatic void mstep();
    real x, y, n1;
    for (int c = 0; c < NCH; c++) begin
      x = si_a[c];
      y = mb0 * x + s1[c];
      if (!((y - y) == 0.0)) begin
        s1[c] = 0.0; s2[c] = 0.0; yp[c] = 0.0;
        ea[c] = 0.0; ee[c] = 0.0;
      end else begin
        n1    = mb1 * x - ma1 * y + s2[c];
        s2[c] = mb2 * x - ma2 * y;
        s1[c] = n1;
        ea[c] = yp[c];
        ee[c] = y;
        yp[c] = y;
      end
    end
  endfunction

  function automatic void mhold();
    for (int c = 0; c < NCH; c++) ea[c] = ee[c];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chkr(string tag, real obs, real exp);
    nchk++;
    assert (close(obs, exp) === 1'b1) npass++;
    else $error("FAIL %s observed=%g expected=%g", tag, obs, exp);
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chkso(string tag);
    for (int c = 0; c < NCH; c++) begin
      chkr($sformatf("%s_a%0d", tag, c), so_a[c], ea[c]);
      chkr($sformatf("%s_y%0d", tag, c), so_a[c] + so_b[c] * TS, ee[c]);
    end
  endtask

  task automatic rnd_si();
    for (int c = 0; c < NCH; c++) si_a[c] = rnd();
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) begin
      rnd_si();
      tick();
      mstep();
      chkso(tag);
    end
  endtask

  task automatic do_cfg(int m, real qq, real ww);
    ifc.mode = 2'(m); ifc.q_a = qq; ifc.w0_a = ww;
    ifc.cfg_valid = 1'b1;
    rnd_si();
    tick();
    mstep();
    ifc.cfg_valid = 1'b0;
    chkb("cfg_busy", ifc.cfg_ready, 1'b0);
    chkso("cfg_acc");
    tick();
    mhold();
    mcoef(m, qq, ww);
    chkb("cfg_back", ifc.cfg_ready, 1'b1);
    chkso("cfg_coef");
  endtask

  task automatic bad_cfg(string tag, real qq);
    ifc.q_a = qq; ifc.cfg_valid = 1'b1;
    rnd_si();
    tick();
    mstep();
    ifc.cfg_valid = 1'b0;
    chkb({tag, "_err"}, ifc.cfg_err, 1'b1);
    chkb({tag, "_rdy"}, ifc.cfg_ready, 1'b1);
    chkso(tag);
    rnd_si();
    tick();
    mstep();
    chkb({tag, "_err_clr"}, ifc.cfg_err, 1'b0);
    chkso(tag);
  endtask

  initial begin
    real w10, o, mx2, mx3, te, lim;
    mreset();
    w10 = 2.0 * PI * 1e7;
    ifc.cfg_valid = 1'b0; ifc.mode = 2'd0;
    ifc.q_a = 0.707; ifc.q_b = 0.0; ifc.q_t0 = 0.0;
    ifc.w0_a = w10; ifc.w0_b = 0.0; ifc.w0_t0 = 0.0;
    for (int c = 0; c < NCH; c++) begin
      si_a[c] = 0.0; si_b[c] = 0.0; si_t0[c] = 0.0;
    end
    @(negedge clk);
    repeat (3) tick();
    chkb("rst_rdy", ifc.cfg_ready, 1'b0);
    chkb("rst_err", ifc.cfg_err, 1'b0);
    chkso("rst");
    rst = 1'b0;
    en  = 1'b1;
    #0.1;
    chkb("rdy_after_rst", ifc.cfg_ready, 1'b1);

    // bypass: step on channel 0 shows up one edge later
    tick(); mstep(); chkso("pre_step");
    si_a[0] = 1.0;
    tick(); mstep();
    chkr("step_start", so_a[0], 0.0);
    chkr("step_end", so_a[0] + so_b[0] * TS, 1.0);
    tick(); mstep();
    chkr("step_settled", so_a[0], 1.0);
    run("bypass", 6);

    // non-finite sample clears only its own channel
    rnd_si();
    si_a[1] = $bitstoreal(64'h7FF0000000000000);
    tick(); mstep();
    chkr("inf_a", so_a[1], 0.0);
    chkr("inf_b", so_b[1], 0.0);
    chkso("inf");
    run("inf_after", 3);

    do_cfg(1, 0.707, w10);
    run("lp", 10);
    for (int i = 0; i < 300; i++) begin
      rnd_si();
      si_a[1] = 0.5;
      tick(); mstep(); chkso("lp_dc");
    end
    o = so_a[1] + so_b[1] * TS;
    chkb("lp_dc_gain", absr(o - 0.5) < 1e-3, 1'b1);

    do_cfg(0, 0.707, w10);
    mx2 = 0.0; mx3 = 0.0;
    for (int i = 0; i < 1500; i++) begin
      rnd_si();
      te = ($realtime + 0.5) * 1e-9;
      si_a[2] = $sin(2.0 * PI * 1e7 * te);
      si_a[3] = $sin(2.0 * PI * 1e6 * te);
      tick(); mstep(); chkso("notch");
      if (i >= 1200) begin
        o = absr(so_a[2] + so_b[2] * TS);
        if (o > mx2) mx2 = o;
      end
      if (i >= 500) begin
        o = absr(so_a[3] + so_b[3] * TS);
        if (o > mx3) mx3 = o;
      end
    end
`ifdef PWL_BIQUAD_PREWARP_EN
    lim = 0.02;
`else
    lim = 0.1;
`endif
    chkb("notch_stop", mx2 < lim, 1'b1);
    chkb("notch_pass", mx3 > 0.95, 1'b1);

    bad_cfg("q_small", 0.01);
    bad_cfg("q_zero", 0.0);
    ifc.q_a = 0.707;
    run("after_reject", 10);

    run("pre_hold", 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_si();
      tick(); mhold();
      chkr("hold_slope", so_b[0], 0.0);
      chkso("hold");
    end
    en = 1'b1;
    run("resume", 5);

    // reset lands while the engine is in COEF
    ifc.mode = 2'd2; ifc.cfg_valid = 1'b1;
    rnd_si();
    tick(); mstep();
    ifc.cfg_valid = 1'b0;
    chkb("coef_busy", ifc.cfg_ready, 1'b0);
    rst = 1'b1;
    tick(); mreset();
    rst = 1'b0;
    #0.1;
    chkb("rst_coef_rdy", ifc.cfg_ready, 1'b1);
    chkso("rst_coef");
    for (int i = 0; i < 4; i++) begin
      rnd_si();
      tick(); mstep();
      chkr("bypass_again", so_a[0] + so_b[0] * TS, si_a[0]);
      chkso("bypass_again");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
